// File: rtl/axi4l2core.sv
// AXI4-Lite responder bridging one AXI4-Lite slave port onto a core-style req/gnt/rvalid
// memory interface; one outstanding transaction, round-robin read/write arbitration.
module axi4l2core #(
    parameter logic [31:0] AddrBase = 32'h0000_0000,
    parameter logic [31:0] AddrMask = 32'h0000_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // AXI4-Lite write address / data / response
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] awaddr_i,
    input  logic [2:0]  awprot_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic [1:0]  bresp_o,
    // AXI4-Lite read address / data
    input  logic        arvalid_i,
    output logic        arready_o,
    input  logic [31:0] araddr_i,
    input  logic [2:0]  arprot_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    // Core-style memory port
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StBresp, StRresp} state_e;

    state_e      state_q, state_d;
    logic        last_rd_q, last_rd_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_cand, rd_cand, grant_wr, grant_rd, acc_hit;
    logic [31:0] acc_addr;
    logic        unused_prot;

    assign unused_prot = ^{awprot_i, arprot_i};

    // Contested cycles go to the kind that did not win the previous accept.
    assign wr_cand  = awvalid_i & wvalid_i;
    assign rd_cand  = arvalid_i;
    assign grant_rd = rd_cand & (~wr_cand | ~last_rd_q);
    assign grant_wr = wr_cand & ~grant_rd;
    assign acc_addr = grant_wr ? awaddr_i : araddr_i;
    assign acc_hit  = (acc_addr & ~AddrMask) == AddrBase;

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        arready_o = 1'b0;
        mem_req_o = 1'b0;
        bvalid_o  = 1'b0;
        rvalid_o  = 1'b0;

        case (state_q)
            StIdle: begin
                awready_o = grant_wr;
                wready_o  = grant_wr;
                arready_o = grant_rd;
                if (grant_wr || grant_rd) begin
                    last_rd_d = grant_rd;
                    we_d      = grant_wr;
                    addr_d    = {acc_addr[31:2], 2'b00};
                    if (grant_wr) begin
                        wdata_d = wdata_i;
                        be_d    = wstrb_i;
                    end else begin
                        be_d    = 4'hF;
                    end
                    if (acc_hit) begin
                        state_d = StReq;
                    end else if (grant_wr) begin
                        bresp_d = RespSlvErr;
                        state_d = StBresp;
                    end else begin
                        rresp_d = RespSlvErr;
                        rdata_d = 32'h0;
                        state_d = StRresp;
                    end
                end
            end
            StReq: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_rvalid_i) begin
                    if (we_q) begin
                        bresp_d = mem_err_i ? RespSlvErr : RespOkay;
                        state_d = StBresp;
                    end else begin
                        rresp_d = mem_err_i ? RespSlvErr : RespOkay;
                        rdata_d = mem_rdata_i;
                        state_d = StRresp;
                    end
                end
            end
            StBresp: begin
                bvalid_o = 1'b1;
                if (bready_i) begin
                    state_d = StIdle;
                end
            end
            StRresp: begin
                rvalid_o = 1'b1;
                if (rready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            last_rd_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            bresp_q   <= RespOkay;
            rresp_q   <= RespOkay;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign bresp_o     = bresp_q;
    assign rresp_o     = rresp_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_axi4l2core.sv
// Randomised and directed bench for axi4l2core against a transaction-level reference model.
module tb_axi4l2core;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i;
    logic        arvalid_i, arready_o, rvalid_o, rready_i;
    logic [31:0] awaddr_i, wdata_i, araddr_i, rdata_o;
    logic [2:0]  awprot_i, arprot_i;
    logic [3:0]  wstrb_i;
    logic [1:0]  bresp_o, rresp_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int total = 0;
    int bad   = 0;

    // Reference model state: arbitration history and last read data returned.
    bit          mdl_last_read;
    logic [31:0] mdl_rdata;

    // Observations from the most recent completion.
    bit          obs_req_seen, obs_stable, obs_hold_ok, obs_drop_ok, obs_other, obs_rdy_leak;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;
    logic        obs_we;
    logic [1:0]  obs_resp;
    int          obs_lat;

    always #5 clk_i = ~clk_i;

    axi4l2core dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i), .awprot_i(awprot_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
        .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i), .arprot_i(arprot_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return a < 32'h0001_0000;
    endfunction

    task automatic start_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        awvalid_i = 1'b1; wvalid_i = 1'b1; awaddr_i = a; wdata_i = d; wstrb_i = s;
        awprot_i = 3'($urandom);
    endtask

    task automatic start_rd(input logic [31:0] a);
        arvalid_i = 1'b1; araddr_i = a; arprot_i = 3'($urandom);
    endtask

    task automatic wait_accept(input bit want_wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (want_wr ? (awready_o && wready_o) : arready_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            tick();
            mdl_last_read = !want_wr;
        end
        if (want_wr) begin
            awvalid_i = 1'b0; wvalid_i = 1'b0;
        end else begin
            arvalid_i = 1'b0;
        end
    endtask

    // Plays the memory side and the response channel; starts in cycle 1 after the handshake.
    task automatic complete(input bit is_wr, input int gnt_stall, input logic [31:0] m_rdata,
                            input bit m_err, input int rdy_stall);
        int cyc;
        bit got;
        obs_req_seen = 0; obs_stable = 1; obs_hold_ok = 1; obs_drop_ok = 1;
        obs_other = 0; obs_rdy_leak = 0; obs_lat = -1;
        cyc = 1;
        if (awready_o || wready_o || arready_o) obs_rdy_leak = 1;
        if (mem_req_o) begin
            obs_req_seen = 1;
            obs_addr = mem_addr_o; obs_be = mem_be_o; obs_we = mem_we_o; obs_wdata = mem_wdata_o;
            for (int s = 0; s < gnt_stall; s++) begin
                tick(); cyc++;
                if (!mem_req_o || mem_addr_o !== obs_addr || mem_be_o !== obs_be ||
                    mem_we_o !== obs_we || mem_wdata_o !== obs_wdata) obs_stable = 0;
                if (awready_o || wready_o || arready_o) obs_rdy_leak = 1;
            end
            mem_gnt_i = 1'b1;
            tick(); cyc++;
            mem_gnt_i = 1'b0;
            if (mem_req_o) obs_stable = 0;
            if (awready_o || wready_o || arready_o) obs_rdy_leak = 1;
            mem_rvalid_i = 1'b1; mem_rdata_i = m_rdata; mem_err_i = m_err;
            tick(); cyc++;
            mem_rvalid_i = 1'b0; mem_rdata_i = $urandom; mem_err_i = 1'($urandom);
        end
        got = 0;
        for (int w = 0; w < 20; w++) begin
            if (is_wr ? bvalid_o : rvalid_o) begin
                got = 1;
                break;
            end
            tick(); cyc++;
        end
        if (!got) return;
        obs_lat = cyc;
        if (is_wr ? rvalid_o : bvalid_o) obs_other = 1;
        obs_resp  = is_wr ? bresp_o : rresp_o;
        obs_rdata = rdata_o;
        for (int r = 0; r < rdy_stall; r++) begin
            tick();
            if (!(is_wr ? bvalid_o : rvalid_o) || (is_wr ? bresp_o : rresp_o) !== obs_resp ||
                rdata_o !== obs_rdata) obs_hold_ok = 0;
            if (awready_o || wready_o || arready_o || mem_req_o) obs_rdy_leak = 1;
        end
        if (is_wr) bready_i = 1'b1; else rready_i = 1'b1;
        tick();
        bready_i = 1'b0; rready_i = 1'b0;
        if (bvalid_o || rvalid_o) obs_drop_ok = 0;
    endtask

    task automatic apply_reset;
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        mdl_last_read = 0;
        mdl_rdata = 32'h0;
    endtask

    task automatic test_reset;
        awvalid_i = 0; wvalid_i = 0; arvalid_i = 0; bready_i = 0; rready_i = 0;
        awaddr_i = 0; wdata_i = 0; wstrb_i = 0; araddr_i = 0; awprot_i = 0; arprot_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
        apply_reset();
        total++;
        if ({awready_o, wready_o, arready_o, bvalid_o, rvalid_o, mem_req_o, mem_we_o} !== 7'h0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {awready_o, wready_o, arready_o, bvalid_o, rvalid_o, mem_req_o, mem_we_o});
        end
        total++;
        if ({bresp_o, rresp_o, mem_be_o} !== 8'h0 || rdata_o !== 0 || mem_addr_o !== 0 ||
            mem_wdata_o !== 0) begin
            bad++;
            $display("FAIL reset_data: got br=%b rr=%b be=%h rd=%h a=%h wd=%h want all zero",
                     bresp_o, rresp_o, mem_be_o, rdata_o, mem_addr_o, mem_wdata_o);
        end
    endtask

    task automatic test_write_hit;
        bit ok;
        start_wr(32'h0000_0104, 32'hDEAD_BEEF, 4'b0011);
        wait_accept(1, ok);
        complete(1, 0, 32'h5555_AAAA, 0, 0);
        total++;
        if (!ok || !obs_req_seen || obs_addr !== 32'h104 || obs_be !== 4'b0011 || obs_we !== 1'b1 ||
            obs_wdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL wr_hit_req: got ok=%0d req=%0d a=%h be=%b we=%b wd=%h want 1 1 104 0011 1 deadbeef",
                     ok, obs_req_seen, obs_addr, obs_be, obs_we, obs_wdata);
        end
        total++;
        if (obs_lat != 3 || obs_resp !== 2'b00 || obs_rdata !== mdl_rdata) begin
            bad++;
            $display("FAIL wr_hit_resp: got lat=%0d resp=%b rdata=%h want 3 00 %h",
                     obs_lat, obs_resp, obs_rdata, mdl_rdata);
        end
    endtask

    task automatic test_read_hit;
        bit ok;
        start_rd(32'h0000_0106);
        wait_accept(0, ok);
        complete(0, 3, 32'h1234_5678, 0, 0);
        mdl_rdata = 32'h1234_5678;
        total++;
        if (!ok || !obs_req_seen || obs_addr !== 32'h104 || obs_be !== 4'hF || obs_we !== 1'b0 ||
            !obs_stable) begin
            bad++;
            $display("FAIL rd_hit_req: got ok=%0d req=%0d a=%h be=%h we=%b stable=%0d want 1 1 104 f 0 1",
                     ok, obs_req_seen, obs_addr, obs_be, obs_we, obs_stable);
        end
        total++;
        if (obs_lat != 6 || obs_resp !== 2'b00 || obs_rdata !== 32'h1234_5678 || obs_rdy_leak) begin
            bad++;
            $display("FAIL rd_hit_resp: got lat=%0d resp=%b rdata=%h leak=%0d want 6 00 12345678 0",
                     obs_lat, obs_resp, obs_rdata, obs_rdy_leak);
        end
    endtask

    task automatic contest(input int k);
        bit ok, exp_rd, got_rd, got_wr;
        logic [31:0] ra, wa, wd;
        ra = 32'h300 + 32'(k * 8); wa = 32'h400 + 32'(k * 8); wd = $urandom;
        start_rd(ra);
        start_wr(wa, wd, 4'hF);
        #1;
        exp_rd = !mdl_last_read;
        got_rd = arready_o;
        got_wr = awready_o && wready_o;
        total++;
        if ({got_rd, got_wr} !== {exp_rd, !exp_rd}) begin
            bad++;
            $display("FAIL arb_grant%0d: got rd=%b wr=%b want rd=%b wr=%b", k, got_rd, got_wr,
                     exp_rd, !exp_rd);
        end
        for (int n = 0; n < 2; n++) begin
            bit this_wr;
            this_wr = (n == 0) ? !exp_rd : exp_rd;
            wait_accept(this_wr, ok);
            complete(this_wr, 0, 32'hC0DE_0000 + 32'(k), 0, 0);
            if (!this_wr) mdl_rdata = 32'hC0DE_0000 + 32'(k);
            total++;
            if (!ok || obs_addr !== (this_wr ? wa : ra) || obs_we !== this_wr ||
                obs_resp !== 2'b00 || obs_rdy_leak || obs_other) begin
                bad++;
                $display("FAIL arb_serve%0d_%0d: got ok=%0d a=%h we=%b resp=%b leak=%0d want 1 %h %b 00 0",
                         k, n, ok, obs_addr, obs_we, obs_resp, obs_rdy_leak,
                         this_wr ? wa : ra, this_wr);
            end
        end
    endtask

    task automatic test_arbitration;
        bit ok;
        apply_reset();
        contest(0);
        contest(1);
        start_rd(32'h500);
        wait_accept(0, ok);
        complete(0, 1, 32'h0BAD_F00D, 0, 0);
        mdl_rdata = 32'h0BAD_F00D;
        contest(2);
    endtask

    task automatic test_miss;
        bit ok;
        start_rd(32'h0001_0000);
        wait_accept(0, ok);
        complete(0, 0, 32'hFFFF_FFFF, 0, 0);
        mdl_rdata = 32'h0;
        total++;
        if (!ok || obs_req_seen || obs_lat != 1 || obs_resp !== 2'b10 || obs_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rd_miss: got ok=%0d req=%0d lat=%0d resp=%b rdata=%h want 1 0 1 10 0",
                     ok, obs_req_seen, obs_lat, obs_resp, obs_rdata);
        end
        start_wr(32'h8000_0000, 32'h1111_2222, 4'hF);
        wait_accept(1, ok);
        complete(1, 0, 32'h0, 0, 0);
        total++;
        if (!ok || obs_req_seen || obs_lat != 1 || obs_resp !== 2'b10) begin
            bad++;
            $display("FAIL wr_miss: got ok=%0d req=%0d lat=%0d resp=%b want 1 0 1 10",
                     ok, obs_req_seen, obs_lat, obs_resp);
        end
    endtask

    task automatic test_err_backpressure;
        bit ok;
        start_rd(32'h40);
        wait_accept(0, ok);
        complete(0, 1, 32'hA5A5_A5A5, 1, 5);
        mdl_rdata = 32'hA5A5_A5A5;
        total++;
        if (!ok || obs_resp !== 2'b10 || obs_rdata !== 32'hA5A5_A5A5 || !obs_hold_ok ||
            !obs_drop_ok || obs_rdy_leak) begin
            bad++;
            $display("FAIL rd_err_hold: got ok=%0d resp=%b rdata=%h hold=%0d drop=%0d leak=%0d want 1 10 a5a5a5a5 1 1 0",
                     ok, obs_resp, obs_rdata, obs_hold_ok, obs_drop_ok, obs_rdy_leak);
        end
    endtask

    task automatic test_aw_only;
        int seen;
        seen = 0;
        awvalid_i = 1'b1; awaddr_i = 32'h80; wvalid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (awready_o || wready_o || mem_req_o || bvalid_o) seen++;
            tick();
        end
        awvalid_i = 1'b0;
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL aw_only: got %0d accepting cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int stray;
        start_rd(32'h200);
        wait_accept(0, ok);
        tick(); tick();
        total++;
        if (!ok || mem_req_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: got ok=%0d req=%b want 1 1", ok, mem_req_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        mdl_last_read = 0; mdl_rdata = 32'h0;
        total++;
        if ({mem_req_o, bvalid_o, rvalid_o, arready_o, mem_we_o, mem_be_o} !== 9'h0 ||
            mem_addr_o !== 0 || rdata_o !== 0) begin
            bad++;
            $display("FAIL rst_mid_outs: got req=%b bv=%b rv=%b be=%h a=%h rd=%h want all zero",
                     mem_req_o, bvalid_o, rvalid_o, mem_be_o, mem_addr_o, rdata_o);
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBEEF_0001;
        tick();
        mem_rvalid_i = 1'b0;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            if (bvalid_o || rvalid_o || mem_req_o || rdata_o !== 0) stray++;
            tick();
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL rst_mid_stray: got %0d reacting cycles want 0", stray);
        end
        start_rd(32'h208);
        wait_accept(0, ok);
        complete(0, 0, 32'h7777_8888, 0, 0);
        mdl_rdata = 32'h7777_8888;
        total++;
        if (!ok || obs_addr !== 32'h208 || obs_lat != 3 || obs_rdata !== 32'h7777_8888) begin
            bad++;
            $display("FAIL rst_mid_after: got ok=%0d a=%h lat=%0d rd=%h want 1 208 3 77778888",
                     ok, obs_addr, obs_lat, obs_rdata);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            bit          is_wr, hit, ok, err;
            logic [31:0] a, d, md, exp_rdata;
            logic [3:0]  s;
            logic [1:0]  exp_resp;
            int          gs, rs, exp_lat;
            is_wr = 1'($urandom);
            a  = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 32'hFFFF))
                                             : ($urandom | 32'h0001_0000);
            d  = $urandom; s = 4'($urandom); md = $urandom;
            err = ($urandom_range(0, 3) == 0);
            gs = $urandom_range(0, 3); rs = $urandom_range(0, 2);
            hit = in_window(a);
            exp_lat  = hit ? 3 + gs : 1;
            exp_resp = (!hit || err) ? 2'b10 : 2'b00;
            if (is_wr) exp_rdata = mdl_rdata;
            else exp_rdata = hit ? md : 32'h0;
            if (is_wr) start_wr(a, d, s); else start_rd(a);
            wait_accept(is_wr, ok);
            complete(is_wr, gs, md, err, rs);
            if (!is_wr) mdl_rdata = exp_rdata;
            total++;
            if (!ok || obs_req_seen !== hit || obs_lat != exp_lat || obs_resp !== exp_resp ||
                obs_rdata !== exp_rdata || !obs_hold_ok || !obs_drop_ok || obs_rdy_leak ||
                obs_other) begin
                bad++;
                $display("FAIL rand%0d_resp: got ok=%0d req=%0d lat=%0d resp=%b rd=%h hold=%0d drop=%0d leak=%0d oth=%0d want 1 %0d %0d %b %h 1 1 0 0",
                         n, ok, obs_req_seen, obs_lat, obs_resp, obs_rdata, obs_hold_ok,
                         obs_drop_ok, obs_rdy_leak, obs_other, hit, exp_lat, exp_resp, exp_rdata);
            end
            if (hit) begin
                total++;
                if (obs_addr !== (a - (a % 4)) || obs_we !== is_wr || !obs_stable ||
                    obs_be !== (is_wr ? s : 4'hF) || (is_wr && obs_wdata !== d)) begin
                    bad++;
                    $display("FAIL rand%0d_req: got a=%h we=%b be=%h wd=%h st=%0d want %h %b %h %h 1",
                             n, obs_addr, obs_we, obs_be, obs_wdata, obs_stable, a - (a % 4),
                             is_wr, is_wr ? s : 4'hF, d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_hit();
        test_read_hit();
        test_arbitration();
        test_miss();
        test_err_backpressure();
        test_aw_only();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
